ysyx_24100012_csr_trap_ctrl: RTL and testbench

YSYX_24100012_CSR_TRAP_CTRL -- requirements
Module: ysyx_24100012_csr_trap_ctrl

---
 rtl/ysyx_24100012_csr_trap_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ysyx_24100012_csr_trap_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_csr_trap_ctrl.sv
// Trap-entry / mret sequencer: writes mepc, mcause and mstatus, then redirects fetch.
// Define YSYX_24100012_CSR_TRAP_IRQ_EN to add the irq/irq_pc interrupt inputs.
module ysyx_24100012_csr_trap_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_type,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  input  logic                  pipe_csr_wen,
  input  logic [11:0]           pipe_csr_idx,
  input  logic [DATA_WIDTH-1:0] pipe_csr_wdata,
  output logic                  pipe_csr_ready,
  output logic                  csr_wen,
  output logic [11:0]           csr_idx,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  redir_valid,
  output logic [ADDR_WIDTH-1:0] redir_pc,
  input  logic                  redir_ready,
`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
  input  logic                  irq,
  input  logic [ADDR_WIDTH-1:0] irq_pc,
`endif
  output logic                  busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MEPC     = 3'd1;
  localparam logic [2:0] S_MCAUSE   = 3'd2;
  localparam logic [2:0] S_MSTATUS  = 3'd3;
  localparam logic [2:0] S_REDIR    = 3'd4;

  localparam logic [1:0] T_ECALL = 2'b00;
  localparam logic [1:0] T_MRET  = 2'b01;
  localparam logic [1:0] T_ILL   = 2'b10;
  localparam logic [1:0] T_IRQ   = 2'b11;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            type_q, type_d;
  logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic                  mie_sh_q, mie_sh_d;
  logic [ADDR_WIDTH-1:0] mtvec_sh_q, mtvec_sh_d;
  logic [ADDR_WIDTH-1:0] mepc_sh_q, mepc_sh_d;
  logic [DATA_WIDTH-1:0] mstatus_new;
  logic                  irq_take;

`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
  assign irq_take = irq && mie_sh_q;
`else
  assign irq_take = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    type_d         = type_q;
    redir_pc_d     = redir_pc_q;
    req_ready      = 1'b0;
    pipe_csr_ready = 1'b0;
    csr_wen        = 1'b0;
    csr_idx        = 12'h000;
    csr_wdata      = '0;
    mstatus_new    = csr_rdata;

    case (state_q)
      S_IDLE: begin
        req_ready      = !irq_take;
        pipe_csr_ready = 1'b1;
        csr_wen        = pipe_csr_wen;
        csr_idx        = pipe_csr_idx;
        csr_wdata      = pipe_csr_wdata;
`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
        if (irq_take) begin
          pc_d    = irq_pc;
          type_d  = T_IRQ;
          state_d = S_MEPC;
        end else
`endif
        if (req_valid) begin
          pc_d   = req_pc;
          type_d = req_type;
          case (req_type)
            T_MRET:  state_d = S_MSTATUS;
            T_IRQ:   state_d = S_IDLE;
            default: state_d = S_MEPC;
          endcase
        end
      end
      S_MEPC: begin
        csr_wen   = 1'b1;
        csr_idx   = A_MEPC;
        csr_wdata = DATA_WIDTH'(pc_q);
        state_d   = S_MCAUSE;
      end
      S_MCAUSE: begin
        csr_wen = 1'b1;
        csr_idx = A_MCAUSE;
        case (type_q)
          T_ILL:   csr_wdata = DATA_WIDTH'(32'h0000_0002);
          T_IRQ:   csr_wdata = DATA_WIDTH'(32'h8000_0007);
          default: csr_wdata = DATA_WIDTH'(32'h0000_000B);
        endcase
        state_d = S_MCAUSE + 3'd1;
      end
      S_MSTATUS: begin
        csr_wen = 1'b1;
        csr_idx = A_MSTATUS;
        // csr_idx is tied up by the mstatus write, so the redirect target comes from shadows.
        if (type_q == T_MRET) begin
          mstatus_new[3] = csr_rdata[7];
          mstatus_new[7] = 1'b1;
          redir_pc_d     = mepc_sh_q;
        end else begin
          mstatus_new[7] = csr_rdata[3];
          mstatus_new[3] = 1'b0;
          redir_pc_d     = mtvec_sh_q & ~(ADDR_WIDTH'(2'b11));
        end
        mstatus_new[12:11] = 2'b11;
        csr_wdata          = mstatus_new;
        state_d            = S_REDIR;
      end
      S_REDIR: begin
        if (redir_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!rst) begin
      req_ready      = 1'b0;
      pipe_csr_ready = 1'b0;
      csr_wen        = 1'b0;
      csr_idx        = 12'h000;
      csr_wdata      = '0;
    end

    mie_sh_d   = mie_sh_q;
    mtvec_sh_d = mtvec_sh_q;
    mepc_sh_d  = mepc_sh_q;
    if (csr_wen) begin
      if (csr_idx == A_MSTATUS) mie_sh_d   = csr_wdata[3];
      if (csr_idx == A_MTVEC)   mtvec_sh_d = ADDR_WIDTH'(csr_wdata);
      if (csr_idx == A_MEPC)    mepc_sh_d  = ADDR_WIDTH'(csr_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      type_q     <= 2'b00;
      redir_pc_q <= '0;
      mie_sh_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      type_q     <= type_d;
      redir_pc_q <= redir_pc_d;
      mie_sh_q   <= mie_sh_d;
    end
  end

  // Shadows mirror CSR contents, which survive reset, so they are not cleared by it.
  always_ff @(posedge clk) begin
    mtvec_sh_q <= mtvec_sh_d;
    mepc_sh_q  <= mepc_sh_d;
  end

  assign redir_valid = rst && (state_q == S_REDIR);
  assign redir_pc    = redir_pc_q;
  assign busy        = rst && (state_q != S_IDLE);

endmodule

// File: tb/tb_ysyx_24100012_csr_trap_ctrl.sv
// Self-checking bench for ysyx_24100012_csr_trap_ctrl against a CSR-file model and a trap reference model.
module tb_ysyx_24100012_csr_trap_ctrl;

  typedef struct {
    int          cyc;
    logic [11:0] idx;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid, req_ready;
  logic [1:0]  req_type;
  logic [31:0] req_pc;
  logic        pipe_csr_wen, pipe_csr_ready;
  logic [11:0] pipe_csr_idx;
  logic [31:0] pipe_csr_wdata;
  logic        csr_wen;
  logic [11:0] csr_idx;
  logic [31:0] csr_wdata, csr_rdata;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic        busy;
`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
  logic        irq;
  logic [31:0] irq_pc;
`endif

  bit [31:0] csr_mem [0:4095];
  bit [31:0] ref_csr [0:4095];
  wr_t       log_q[$];
  wr_t       exp_q[$];
  wr_t       log_e;
  int        cyc = 0;
  int        vectors = 0;
  int        miscompares = 0;

  ysyx_24100012_csr_trap_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_pc(req_pc),
    .pipe_csr_wen(pipe_csr_wen), .pipe_csr_idx(pipe_csr_idx),
    .pipe_csr_wdata(pipe_csr_wdata), .pipe_csr_ready(pipe_csr_ready),
    .csr_wen(csr_wen), .csr_idx(csr_idx), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
    .irq(irq), .irq_pc(irq_pc),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign csr_rdata = csr_mem[csr_idx];

  // CSR file: combinational read, write on the rising edge; every write is logged with its edge number.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (csr_wen === 1'b1) begin
      log_e.cyc  = cyc;
      log_e.idx  = csr_idx;
      log_e.data = csr_wdata;
      log_q.push_back(log_e);
      csr_mem[csr_idx] <= csr_wdata;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit [31:0] m_trap(input bit [31:0] m);
    bit [31:0] r;
    r = m & ~32'h0000_1888;
    if ((m & 32'h8) != 0) r = r | 32'h80;
    return r | 32'h1800;
  endfunction

  function automatic bit [31:0] m_mret(input bit [31:0] m);
    bit [31:0] r;
    r = m & ~32'h0000_1888;
    if ((m & 32'h80) != 0) r = r | 32'h8;
    return r | 32'h1880;
  endfunction

  task automatic pipe_write(input logic [11:0] idx, input logic [31:0] d);
    @(negedge clk);
    pipe_csr_wen = 1'b1; pipe_csr_idx = idx; pipe_csr_wdata = d;
    ref_csr[idx] = d;
    @(negedge clk);
    pipe_csr_wen = 1'b0;
  endtask

  // Runs a sequence already accepted at edge 'acc' through to the redirect handshake and checks it.
  task automatic run_sequence(input logic [1:0] kind, input logic [31:0] epc, input int acc,
                              input int stall, input bit noise);
    wr_t         e;
    logic [31:0] ms, exp_redir, cause;
    int          first_exp, first_seen;
    exp_q.delete();
    ms = ref_csr[12'h300];
    if (kind == 2'b01) begin
      e.cyc = acc + 1; e.idx = 12'h300; e.data = m_mret(ms); exp_q.push_back(e);
      exp_redir = ref_csr[12'h341];
      first_exp = acc + 1;
    end else begin
      cause = (kind == 2'b00) ? 32'hB : (kind == 2'b10) ? 32'h2 : 32'h8000_0007;
      e.cyc = acc + 1; e.idx = 12'h341; e.data = epc;        exp_q.push_back(e);
      e.cyc = acc + 2; e.idx = 12'h342; e.data = cause;      exp_q.push_back(e);
      e.cyc = acc + 3; e.idx = 12'h300; e.data = m_trap(ms); exp_q.push_back(e);
      exp_redir = ref_csr[12'h305] & 32'hFFFF_FFFC;
      first_exp = acc + 3;
    end
    foreach (exp_q[i]) ref_csr[exp_q[i].idx] = exp_q[i].data;

    first_seen = -1;
    for (int b = 0; b < 20; b++) begin
      #1;
      if (noise && redir_valid !== 1'b1) begin
        vectors++;
        if (req_ready !== 1'b0 || pipe_csr_ready !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL busy_block: req_ready=%b pipe_csr_ready=%b, want 0/0", req_ready, pipe_csr_ready);
        end
      end
      if (redir_valid === 1'b1) begin
        first_seen = cyc;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (first_seen != first_exp) begin
      miscompares++;
      $display("[TB] FAIL redir_latency: first redir_valid after edge %0d, want %0d", first_seen, first_exp);
    end
    vectors++;
    if (redir_pc !== exp_redir) begin
      miscompares++;
      $display("[TB] FAIL redir_pc: got %h want %h", redir_pc, exp_redir);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      vectors++;
      if (redir_valid !== 1'b1 || redir_pc !== exp_redir) begin
        miscompares++;
        $display("[TB] FAIL redir_hold: valid=%b pc=%h, want 1 %h", redir_valid, redir_pc, exp_redir);
      end
    end
    redir_ready = 1'b1; req_valid = 1'b0; pipe_csr_wen = 1'b0;
    @(negedge clk);
    redir_ready = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || redir_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL return_idle: busy=%b redir_valid=%b req_ready=%b, want 0 0 1", busy, redir_valid, req_ready);
    end
    vectors++;
    if (log_q.size() != exp_q.size()) begin
      miscompares++;
      $display("[TB] FAIL csr_write_count: got %0d want %0d", log_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (log_q[i].cyc != exp_q[i].cyc || log_q[i].idx !== exp_q[i].idx || log_q[i].data !== exp_q[i].data) begin
          miscompares++;
          $display("[TB] FAIL csr_write[%0d]: got edge %0d idx %h data %h, want edge %0d idx %h data %h", i,
                   log_q[i].cyc, log_q[i].idx, log_q[i].data, exp_q[i].cyc, exp_q[i].idx, exp_q[i].data);
        end
      end
    end
  endtask

  task automatic do_req(input logic [1:0] t, input logic [31:0] pc, input int stall, input bit noise);
    int acc;
    @(negedge clk);
    log_q.delete();
    req_valid = 1'b1; req_type = t; req_pc = pc;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL req_ready_idle: got %b want 1", req_ready);
    end
    acc = cyc + 1;
    @(negedge clk);
    if (noise) begin
      pipe_csr_wen = 1'b1; pipe_csr_idx = 12'h341; pipe_csr_wdata = 32'hDEAD_BEEF;
    end else begin
      req_valid = 1'b0;
    end
    if (t == 2'b11) begin
      req_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #1;
        vectors++;
        if (busy !== 1'b0 || redir_valid !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL reserved_idle: busy=%b redir_valid=%b want 0 0", busy, redir_valid);
        end
        @(negedge clk);
      end
      vectors++;
      if (log_q.size() != 0) begin
        miscompares++;
        $display("[TB] FAIL reserved_writes: got %0d CSR writes want 0", log_q.size());
      end
    end else begin
      run_sequence(t, pc, acc, stall, noise);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1; pipe_csr_wen = 1'b1; pipe_csr_idx = 12'h300; pipe_csr_wdata = 32'hFF;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b0 || pipe_csr_ready !== 1'b0 || csr_wen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: req_ready=%b pipe_csr_ready=%b csr_wen=%b want 0 0 0", req_ready, pipe_csr_ready, csr_wen);
    end
    vectors++;
    if (busy !== 1'b0 || redir_valid !== 1'b0 || redir_pc !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: busy=%b redir_valid=%b redir_pc=%h want 0 0 0", busy, redir_valid, redir_pc);
    end
    req_valid = 1'b0; pipe_csr_wen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || pipe_csr_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: req_ready=%b pipe_csr_ready=%b busy=%b want 1 1 0", req_ready, pipe_csr_ready, busy);
    end
  endtask

  task automatic test_passthrough();
    logic        w;
    logic [11:0] idx;
    logic [31:0] d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = 1'($urandom_range(0, 1)); idx = 12'($urandom); d = $urandom;
      pipe_csr_wen = w; pipe_csr_idx = idx; pipe_csr_wdata = d;
      #1;
      vectors++;
      if (csr_wen !== w || csr_idx !== idx || csr_wdata !== d || pipe_csr_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL passthrough: got wen=%b idx=%h data=%h, want %b %h %h", csr_wen, csr_idx, csr_wdata, w, idx, d);
      end
      if (w) ref_csr[idx] = d;
    end
    @(negedge clk);
    pipe_csr_wen = 1'b0;
  endtask

  task automatic test_ecall();
    pipe_write(12'h305, 32'h8000_0005);
    pipe_write(12'h300, 32'h0000_0008);
    do_req(2'b00, 32'h8000_0100, 0, 1'b1);
    vectors++;
    if (csr_mem[12'h341] !== 32'h8000_0100 || csr_mem[12'h342] !== 32'hB || csr_mem[12'h300] !== 32'h1880) begin
      miscompares++;
      $display("[TB] FAIL ecall_csrs: mepc=%h mcause=%h mstatus=%h want 80000100 0000000b 00001880",
               csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
    end
  endtask

  task automatic test_mret();
    pipe_write(12'h341, 32'h8000_0104);
    pipe_write(12'h300, 32'h0000_0080);
    do_req(2'b01, 32'h8000_0010, 0, 1'b0);
    vectors++;
    if (csr_mem[12'h300] !== 32'h1888) begin
      miscompares++;
      $display("[TB] FAIL mret_mstatus: got %h want 00001888", csr_mem[12'h300]);
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    pipe_write(12'h305, 32'h8000_0300);
    @(negedge clk);
    log_q.delete();
    req_valid = 1'b1; req_type = 2'b00; req_pc = 32'h8000_0440;
    acc = cyc + 1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (csr_wen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_wen: csr_wen=%b want 0", csr_wen);
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || redir_valid !== 1'b0 || redir_pc !== 32'h0 || req_ready !== 1'b0 || pipe_csr_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_outputs: busy=%b rv=%b rpc=%h rr=%b pr=%b want all 0",
               busy, redir_valid, redir_pc, req_ready, pipe_csr_ready);
    end
    vectors++;
    if (log_q.size() != 1 || log_q[0].cyc != acc + 1 || log_q[0].idx !== 12'h341 || log_q[0].data !== 32'h8000_0440) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_writes: %0d writes logged, want only mepc=80000440 at edge %0d", log_q.size(), acc + 1);
    end
    ref_csr[12'h341] = 32'h8000_0440;
    vectors++;
    if (csr_mem[12'h342] !== ref_csr[12'h342]) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_mcause: got %h want %h", csr_mem[12'h342], ref_csr[12'h342]);
    end
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    pipe_write(12'h305, 32'h8000_0800);
    do_req(2'b10, 32'h8000_0a0c, 0, 1'b0);
    do_req(2'b01, 32'h0, 1, 1'b0);
  endtask

`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
  task automatic test_irq();
    int acc;
    pipe_write(12'h305, 32'h8000_0200);
    pipe_write(12'h300, 32'h0000_0008);
    @(negedge clk);
    log_q.delete();
    irq = 1'b1; irq_pc = 32'h8000_0400; req_valid = 1'b1; req_type = 2'b00; req_pc = 32'h8000_0500;
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL irq_priority: req_ready=%b want 0", req_ready);
    end
    acc = cyc + 1;
    @(negedge clk);
    irq = 1'b0; req_valid = 1'b0;
    run_sequence(2'b11, 32'h8000_0400, acc, 1, 1'b0);
    @(negedge clk);
    log_q.delete();
    irq = 1'b1; req_valid = 1'b1; req_type = 2'b11;
    #1;
    vectors++;
    if (req_ready !== (ref_csr[12'h300][3] == 1'b0)) begin
      miscompares++;
      $display("[TB] FAIL irq_masked: req_ready=%b want %b", req_ready, ref_csr[12'h300][3] == 1'b0);
    end
    @(negedge clk);
    irq = 1'b0; req_valid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || log_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL irq_masked_idle: busy=%b writes=%0d want 0 0", busy, log_q.size());
    end
  endtask
`endif

  task automatic test_random();
    logic [1:0] t;
    for (int i = 0; i < 12; i++) begin
      pipe_write(12'h305, $urandom);
      pipe_write(12'h300, $urandom);
      if ($urandom_range(0, 1) == 1) pipe_write(12'h341, $urandom & 32'hFFFF_FFFC);
      t = 2'($urandom_range(0, 3));
      do_req(t, $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)), (t != 2'b11) && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    req_valid = 1'b0; req_type = 2'b00; req_pc = 32'h0;
    pipe_csr_wen = 1'b0; pipe_csr_idx = 12'h0; pipe_csr_wdata = 32'h0; redir_ready = 1'b0;
`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
    irq = 1'b0; irq_pc = 32'h0;
`endif
    test_reset();
    test_passthrough();
    test_ecall();
    test_mret();
    do_req(2'b10, $urandom & 32'hFFFF_FFFC, 3, 1'b0);
    do_req(2'b11, 32'h8000_0020, 0, 1'b0);
    test_reset_mid();
    test_back_to_back();
`ifdef YSYX_24100012_CSR_TRAP_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
